// File: rtl/mydither_write_combiner.sv
// Write combiner between the drawing engine and the framebuffer: merges byte writes to
// one word address into a single downstream write; reads are passed through in order.
module mydither_write_combiner #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic        mem_rnw,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, READ} state_t;

  state_t      state_q, state_d;
  logic [17:0] buf_addr_q, buf_addr_d;
  logic [3:0]  buf_mask_q, buf_mask_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_done_q, rd_done_d;
  logic [31:0] de_r_data_q, de_r_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_rnw_q, mem_rnw_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_nbyte_q, mem_nbyte_d;
  logic [31:0] mem_w_data_q, mem_w_data_d;

  logic [31:0] wr_bits;
  logic        addr_hit;
  logic        wr_xfer;
  logic        wr_take;
  logic        timeout_hit;
  logic        flush_go;

  assign wr_bits     = {{8{~de_nbyte[3]}}, {8{~de_nbyte[2]}},
                        {8{~de_nbyte[1]}}, {8{~de_nbyte[0]}}};
  assign addr_hit    = (de_addr == buf_addr_q);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    de_ack = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    de_ack = de_req && !de_rnw;
        FILL:    de_ack = de_req && !de_rnw && addr_hit;
        READ:    de_ack = rd_done_q;
        default: de_ack = 1'b0;
      endcase
    end
  end

  // An all-ones byte enable is acknowledged but leaves buffer and timer untouched.
  assign wr_xfer = de_ack && de_req && !de_rnw && (state_q == IDLE || state_q == FILL);
  assign wr_take = wr_xfer && (de_nbyte != 4'hF);

  always_comb begin
    state_d      = state_q;
    buf_addr_d   = buf_addr_q;
    buf_mask_d   = buf_mask_q;
    buf_data_d   = buf_data_q;
    cnt_d        = cnt_q;
    rd_done_d    = rd_done_q;
    de_r_data_d  = de_r_data_q;
    mem_req_d    = mem_req_q;
    mem_rnw_d    = mem_rnw_q;
    mem_addr_d   = mem_addr_q;
    mem_nbyte_d  = mem_nbyte_q;
    mem_w_data_d = mem_w_data_q;
    flush_go     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (de_req && de_rnw) begin
          state_d     = READ;
          mem_req_d   = 1'b1;
          mem_rnw_d   = 1'b1;
          mem_addr_d  = de_addr;
          mem_nbyte_d = de_nbyte;
          rd_done_d   = 1'b0;
        end else if (wr_take) begin
          buf_addr_d = de_addr;
          buf_mask_d = de_nbyte;
          buf_data_d = de_w_data & wr_bits;
          cnt_d      = 8'd0;
          state_d    = FILL;
        end
      end

      FILL: begin
        if (wr_take) begin
          buf_mask_d = buf_mask_q & de_nbyte;
          buf_data_d = (buf_data_q & ~wr_bits) | (de_w_data & wr_bits);
          cnt_d      = 8'd0;
        end
        if (buf_mask_q == 4'h0 || (de_req && (de_rnw || !addr_hit))) begin
          flush_go = 1'b1;
        end else if (!wr_xfer) begin
          if (timeout_hit) flush_go = 1'b1;
          else             cnt_d    = cnt_q + 8'd1;
        end
        // Load the downstream word from the post-merge buffer value.
        if (flush_go) begin
          state_d      = FLUSH;
          mem_req_d    = 1'b1;
          mem_rnw_d    = 1'b0;
          mem_addr_d   = buf_addr_d;
          mem_nbyte_d  = buf_mask_d;
          mem_w_data_d = buf_data_d;
          cnt_d        = 8'd0;
        end
      end

      FLUSH: begin
        if (mem_req_q && mem_ack) begin
          buf_mask_d = 4'hF;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end

      READ: begin
        if (rd_done_q) begin
          rd_done_d = 1'b0;
          state_d   = IDLE;
        end else if (mem_req_q && mem_ack) begin
          de_r_data_d = mem_r_data;
          mem_req_d   = 1'b0;
          rd_done_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_addr_q   <= 18'd0;
      buf_mask_q   <= 4'hF;
      buf_data_q   <= 32'd0;
      cnt_q        <= 8'd0;
      rd_done_q    <= 1'b0;
      de_r_data_q  <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_rnw_q    <= 1'b0;
      mem_addr_q   <= 18'd0;
      mem_nbyte_q  <= 4'hF;
      mem_w_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      buf_addr_q   <= buf_addr_d;
      buf_mask_q   <= buf_mask_d;
      buf_data_q   <= buf_data_d;
      cnt_q        <= cnt_d;
      rd_done_q    <= rd_done_d;
      de_r_data_q  <= de_r_data_d;
      mem_req_q    <= mem_req_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_addr_q   <= mem_addr_d;
      mem_nbyte_q  <= mem_nbyte_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

  assign de_r_data  = de_r_data_q;
  assign mem_req    = mem_req_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_nbyte  = mem_nbyte_q;
  assign mem_w_data = mem_w_data_q;

endmodule

// File: tb/tb_mydither_write_combiner.sv
// Directed bench for the write combiner with a small framebuffer responder that logs
// every completed downstream transaction.
module tb_mydither_write_combiner;

  logic        clk;
  logic        rst;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;
  logic        mem_req;
  logic        mem_ack;
  logic [17:0] mem_addr;
  logic [3:0]  mem_nbyte;
  logic        mem_rnw;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int          ackDelay = 0;
  int          waitCnt;
  logic [31:0] memReadValue = 32'h0;

  logic [17:0] qAddr[$];
  logic [3:0]  qNbyte[$];
  logic [31:0] qData[$];
  logic        qRnw[$];

  mydither_write_combiner #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_nbyte  (mem_nbyte),
    .mem_rnw    (mem_rnw),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer model: acknowledges a request after ackDelay waiting cycles and logs it.
  initial begin
    mem_ack    = 1'b0;
    mem_r_data = 32'h0;
    waitCnt    = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else if (mem_req === 1'b1 && rst === 1'b0) begin
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1;
          qAddr.push_back(mem_addr);
          qNbyte.push_back(mem_nbyte);
          qData.push_back(mem_w_data);
          qRnw.push_back(mem_rnw);
          if (mem_rnw) mem_r_data = memReadValue;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Last-resort guard so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before the sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic rnw, input logic [17:0] addr,
                               input logic [3:0] nbyte, input logic [31:0] data);
    de_req    = req;
    de_rnw    = rnw;
    de_addr   = addr;
    de_nbyte  = nbyte;
    de_w_data = data;
  endtask

  task automatic clearLog();
    qAddr.delete();
    qNbyte.delete();
    qData.delete();
    qRnw.delete();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at 1ns after an edge; samples at 2ns after each edge until de_ack or the bound.
  task automatic waitDeAck(input int maxCycles);
    int waited;
    waited = 0;
    #1;
    while (de_ack !== 1'b1 && waited < maxCycles) begin
      @(posedge clk);
      #2;
      waited++;
    end
  endtask

  task automatic doWrite(input logic [17:0] addr, input logic [3:0] nbyte,
                         input logic [31:0] data, input string tag);
    applyStimulus(1'b1, 1'b0, addr, nbyte, data);
    waitDeAck(50);
    checkOutput(tag, 32'(de_ack), 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
  endtask

  task automatic checkTxn(input string tag, input int idx, input logic rnw,
                          input logic [17:0] addr, input logic [3:0] nbyte, input logic [31:0] data);
    if (qAddr.size() <= idx) begin
      checkOutput({tag, "Exists"}, 32'(qAddr.size()), 32'(idx + 1));
    end else begin
      checkOutput({tag, "Rnw"}, 32'(qRnw[idx]), 32'(rnw));
      checkOutput({tag, "Addr"}, 32'(qAddr[idx]), 32'(addr));
      checkOutput({tag, "Nbyte"}, 32'(qNbyte[idx]), 32'(nbyte));
      if (!rnw) checkOutput({tag, "Data"}, qData[idx], data);
    end
  endtask

  initial begin
    int   waited;
    int   reqCycles;
    logic stable;
    logic deAckHigh;
    logic earlyReq;

    // Reset holds everything quiet even with a write request pending.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 18'h00010, 4'h0, 32'hFFFFFFFF);
    idleCycles(3);
    checkOutput("rstDeAck", 32'(de_ack), 32'h0);
    checkOutput("rstMemReq", 32'(mem_req), 32'h0);
    checkOutput("rstRData", de_r_data, 32'h0);
    checkOutput("rstMemRnw", 32'(mem_rnw), 32'h0);
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
    rst = 1'b0;
    idleCycles(2);

    // Four byte writes to one word combine into a single full-word write.
    clearLog();
    doWrite(18'h00010, 4'b1110, 32'hFFFFFF11, "comb0");
    doWrite(18'h00010, 4'b1101, 32'hFFFF22FF, "comb1");
    doWrite(18'h00010, 4'b1011, 32'hFF33FFFF, "comb2");
    doWrite(18'h00010, 4'b0111, 32'h44FFFFFF, "comb3");
    idleCycles(6);
    checkOutput("combCount", 32'(qAddr.size()), 32'd1);
    checkTxn("comb", 0, 1'b0, 18'h00010, 4'b0000, 32'h44332211);

    // A write to another address is held off until the buffer has been flushed.
    clearLog();
    doWrite(18'h00020, 4'b1110, 32'h000000A5, "wr20");
    applyStimulus(1'b1, 1'b0, 18'h00021, 4'b1110, 32'hFFFFFFB6);
    #1;
    checkOutput("holdOff21", 32'(de_ack), 32'h0);
    waitDeAck(30);
    checkOutput("ack21", 32'(de_ack), 32'h1);
    checkOutput("flushBefore21", 32'(qAddr.size()), 32'd1);
    checkTxn("fl20", 0, 1'b0, 18'h00020, 4'b1110, 32'h000000A5);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
    idleCycles(24);
    checkTxn("fl21", 1, 1'b0, 18'h00021, 4'b1110, 32'h000000B6);

    // Idle timeout: the flush request appears exactly 16 cycles after acceptance.
    clearLog();
    doWrite(18'h00040, 4'b1011, 32'hAA77AAAA, "wr40");
    earlyReq = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b0) earlyReq = 1'b1;
    end
    checkOutput("noEarlyFlush", 32'(earlyReq), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("timeoutReq", 32'(mem_req), 32'h1);
    idleCycles(4);
    checkTxn("fl40", 0, 1'b0, 18'h00040, 4'b1011, 32'h00770000);

    // Downstream stall: flush outputs stay put and upstream stays held off.
    clearLog();
    doWrite(18'h00050, 4'b0110, 32'h12FFFF34, "wr50");
    ackDelay = 5;
    applyStimulus(1'b1, 1'b0, 18'h00051, 4'b1110, 32'h000000C7);
    stable    = 1'b1;
    deAckHigh = 1'b0;
    reqCycles = 0;
    waited    = 0;
    #2;
    while (!(mem_req === 1'b1 && mem_ack === 1'b1) && waited < 40) begin
      if (de_ack !== 1'b0) deAckHigh = 1'b1;
      if (mem_req === 1'b1) begin
        reqCycles++;
        if (mem_addr !== 18'h00050 || mem_nbyte !== 4'b0110 || mem_w_data !== 32'h12000034)
          stable = 1'b0;
      end
      @(posedge clk);
      #3;
      waited++;
    end
    checkOutput("stallStable", 32'(stable), 32'h1);
    checkOutput("stallDeAck", 32'(deAckHigh), 32'h0);
    checkOutput("stallCycles", 32'(reqCycles), 32'd5);
    ackDelay = 0;
    @(posedge clk);
    #1;
    waitDeAck(10);
    checkOutput("ack51", 32'(de_ack), 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
    idleCycles(24);
    checkTxn("fl50", 0, 1'b0, 18'h00050, 4'b0110, 32'h12000034);
    checkTxn("fl51", 1, 1'b0, 18'h00051, 4'b1110, 32'h000000C7);

    // Read after a partial write: flush goes first, then the read, one-cycle ack.
    clearLog();
    memReadValue = 32'hCAFEF00D;
    doWrite(18'h00030, 4'b1100, 32'h1234BEEF, "wr30");
    applyStimulus(1'b1, 1'b1, 18'h00030, 4'b0000, 32'h0);
    #1;
    checkOutput("rdHoldOff", 32'(de_ack), 32'h0);
    waitDeAck(30);
    checkOutput("rdAck", 32'(de_ack), 32'h1);
    checkTxn("rdFlush", 0, 1'b0, 18'h00030, 4'b1100, 32'h0000BEEF);
    checkTxn("rdMem", 1, 1'b1, 18'h00030, 4'b0000, 32'h0);
    checkOutput("rdData", de_r_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    checkOutput("rdAckOnce", 32'(de_ack), 32'h0);
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
    idleCycles(3);
    checkOutput("rdCount", 32'(qAddr.size()), 32'd2);

    // A write with no bytes enabled is acknowledged and dropped; read data is retained.
    clearLog();
    applyStimulus(1'b1, 1'b0, 18'h00080, 4'hF, 32'hFFFFFFFF);
    #1;
    checkOutput("discardAck", 32'(de_ack), 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 18'h0, 4'hF, 32'h0);
    idleCycles(22);
    checkOutput("discardNoTxn", 32'(qAddr.size()), 32'd0);
    checkOutput("rdDataHeld", de_r_data, 32'hCAFEF00D);

    // Reset in the middle of a stalled flush drops the request and the buffered bytes.
    clearLog();
    ackDelay = 1000;
    doWrite(18'h00060, 4'b1110, 32'h000000EE, "wr60");
    waited = 0;
    #1;
    while (mem_req !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checkOutput("rstFlushReq", 32'(mem_req), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstDropReq", 32'(mem_req), 32'h0);
    checkOutput("rstDropRData", de_r_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ackDelay = 0;
    idleCycles(22);
    checkOutput("rstNoTxn", 32'(qAddr.size()), 32'd0);
    doWrite(18'h00070, 4'b1101, 32'hFFFF33FF, "wr70");
    idleCycles(22);
    checkTxn("fl70", 0, 1'b0, 18'h00070, 4'b1101, 32'h00003300);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
